// File: rtl/pipelined_mac_array.sv
// Multi-lane two-stage multiply-accumulate engine: registered products, then per-lane
// accumulation over in_last-framed packets, one result vector per packet on a valid/ready stream.
module pipelined_mac_array #(
    parameter int DATA_WIDTH   = 32,
    parameter int WEIGHT_WIDTH = 8,
    parameter int LANES        = 4,
    parameter bit SATURATE     = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic [LANES*DATA_WIDTH-1:0]     in_data,
    input  logic [LANES*WEIGHT_WIDTH-1:0]   in_weight,
    input  logic [LANES*DATA_WIDTH-1:0]     in_bias,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*DATA_WIDTH-1:0]     out_data,
    output logic                            busy
);

    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int SW = PW + 1;

    logic                  r_first;
    logic                  r_s1_valid;
    logic                  r_s1_first;
    logic                  r_s1_last;
    logic                  r_out_valid;
    logic [PW-1:0]         r_prod [LANES];
    logic [DATA_WIDTH-1:0] r_bias [LANES];
    logic [DATA_WIDTH-1:0] r_acc  [LANES];
    logic [DATA_WIDTH-1:0] r_out  [LANES];
    logic [SW-1:0]         w_sum  [LANES];
    logic [DATA_WIDTH-1:0] w_next [LANES];
    logic                  w_advance;

    // Only a completed result that cannot leave the output register stalls the pipe.
    assign w_advance = !(r_s1_valid && r_s1_last) || !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign busy      = r_s1_valid || !r_first;

    // Saturation is sticky without extra state: an all-ones accumulator plus any product clamps again.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_sum[i] = SW'(r_s1_first ? r_bias[i] : r_acc[i]) + SW'(r_prod[i]);
            if (SATURATE && (w_sum[i][SW-1:DATA_WIDTH] != '0))
                w_next[i] = '1;
            else
                w_next[i] = w_sum[i][DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++)
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = r_out[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first     <= 1'b1;
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
                r_bias[i] <= '0;
                r_acc[i]  <= '0;
                r_out[i]  <= '0;
            end
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_first    <= in_last;
                r_s1_first <= r_first;
                r_s1_last  <= in_last;
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= PW'(in_data[i*DATA_WIDTH +: DATA_WIDTH])
                               * PW'(in_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
                    if (r_first)
                        r_bias[i] <= in_bias[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (r_s1_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    r_acc[i] <= w_next[i];
                    if (r_s1_last)
                        r_out[i] <= w_next[i];
                end
            end
            if (r_s1_valid && r_s1_last)
                r_out_valid <= 1'b1;
            else if (out_ready)
                r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_mac_array.sv
// Directed and randomized checks of pipelined_mac_array against a running-sum packet model;
// two 16-bit single-lane instances cover wrap-around versus saturation.
module tb_pipelined_mac_array;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [127:0] in_data;
    logic [31:0]  in_weight;
    logic [127:0] in_bias;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         s_valid, s_last, s_oready;
    logic [15:0]  s_data, s_bias;
    logic [7:0]   s_weight;
    logic         wrap_ready, wrap_ovalid, wrap_busy;
    logic [15:0]  wrap_odata;
    logic         sat_ready, sat_ovalid, sat_busy;
    logic [15:0]  sat_odata;

    int compared = 0;
    int mism     = 0;
    int n_stall  = 0;

    logic [31:0]  m_acc [4];
    logic         m_first = 1'b1;
    logic [127:0] exp_q [$];

    pipelined_mac_array #(.DATA_WIDTH(32), .WEIGHT_WIDTH(8), .LANES(4), .SATURATE(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy));

    pipelined_mac_array #(.DATA_WIDTH(16), .WEIGHT_WIDTH(8), .LANES(1), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(wrap_ready), .in_last(s_last),
        .in_data(s_data), .in_weight(s_weight), .in_bias(s_bias), .out_valid(wrap_ovalid),
        .out_ready(s_oready), .out_data(wrap_odata), .busy(wrap_busy));

    pipelined_mac_array #(.DATA_WIDTH(16), .WEIGHT_WIDTH(8), .LANES(1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(sat_ready), .in_last(s_last),
        .in_data(s_data), .in_weight(s_weight), .in_bias(s_bias), .out_valid(sat_ovalid),
        .out_ready(s_oready), .out_data(sat_odata), .busy(sat_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        compared++;
        assert (obs === expv) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Packet-level model: lane sum = bias + sum(data*weight) mod 2^32.
    task automatic model_accept(input logic [127:0] d, input logic [31:0] w,
                                input logic [127:0] b, input logic last);
        logic [127:0] v;
        logic [63:0]  p;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            p = 64'(d[i*32 +: 32]) * 64'(w[i*8 +: 8]);
            m_acc[i] = (m_first ? b[i*32 +: 32] : m_acc[i]) + p[31:0];
            v[i*32 +: 32] = m_acc[i];
        end
        if (last) exp_q.push_back(v);
        m_first = last;
    endtask

    // One clock; any output handshake about to happen is scored against the model first.
    task automatic tick();
        logic [127:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", out_data, 128'hx);
            end else begin
                e = exp_q.pop_front();
                check("result", out_data, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic [31:0] w,
                        input logic [127:0] b, input logic last);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_weight = w;
        in_bias   = b;
        in_last   = last;
        for (int k = 0; k < 50 && !done; k++) begin
            if (in_ready) begin
                model_accept(d, w, b, last);
                done = 1'b1;
            end else begin
                n_stall++;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        check("queue_empty", 128'(exp_q.size()), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        in_valid = 0; in_last = 0; in_data = '0; in_weight = '0; in_bias = '0; out_ready = 1;
        s_valid = 0; s_last = 0; s_data = '0; s_weight = '0; s_bias = '0; s_oready = 1;
        for (int i = 0; i < 4; i++) m_acc[i] = '0;
        rst = 0;
        #1 rst = 1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_small_idle", {wrap_busy, sat_busy, wrap_ready, sat_ready}, 4'b0011);
        @(posedge clk);
        #1 rst = 0;
        tick();

        // Three-beat packet, lane0 bias 10: 10 + 1*4 + 2*5 + 3*6 = 42, valid two edges after last.
        send({rnd128() >> 32, 32'd1}, {$urandom_range(255), $urandom_range(255), $urandom_range(255), 8'd4},
             {rnd128() >> 32, 32'd10}, 1'b0);
        check("busy_mid_packet", busy, 1'b1);
        send({rnd128() >> 32, 32'd2}, {$urandom_range(255), $urandom_range(255), $urandom_range(255), 8'd5},
             rnd128(), 1'b0);
        send({rnd128() >> 32, 32'd3}, {$urandom_range(255), $urandom_range(255), $urandom_range(255), 8'd6},
             rnd128(), 1'b1);
        check("lat_not_yet", out_valid, 1'b0);
        tick();
        check("lat_valid", out_valid, 1'b1);
        check("lane0_42", out_data[31:0], 32'd42);
        tick();

        // Single-beat packets use bias + product; second packet picks up its own bias.
        send({rnd128() >> 32, 32'd7}, {rnd128() >> 8, 8'd255}, {rnd128() >> 32, 32'd0}, 1'b1);
        tick();
        check("single_1785", out_data[31:0], 32'd1785);
        send({rnd128() >> 32, 32'd1}, {rnd128() >> 8, 8'd1}, {rnd128() >> 32, 32'd5}, 1'b1);
        tick();
        check("fresh_bias", out_data[31:0], 32'd6);
        drain();

        // Backpressure: two 2-beat packets with out_ready low.
        out_ready = 0;
        send(rnd128(), $urandom, rnd128(), 1'b0);
        send(rnd128(), $urandom, rnd128(), 1'b1);
        send(rnd128(), $urandom, rnd128(), 1'b0);
        send(rnd128(), $urandom, rnd128(), 1'b1);
        check("stall_in_ready", in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("held_valid", out_valid, 1'b1);
            check("held_data", out_data, exp_q[0]);
            tick();
        end
        check("stall_busy", busy, 1'b1);
        out_ready = 1;
        drain();

        // Saturating versus wrapping, 16-bit lanes.
        s_valid = 1; s_last = 1; s_data = 16'd1; s_weight = 8'd32; s_bias = 16'hFFF0;
        tick();
        s_valid = 0;
        tick();
        check("wrap_valid", wrap_ovalid, 1'b1);
        check("wrap_single", wrap_odata, 16'h0010);
        check("sat_single", sat_odata, 16'hFFFF);
        s_valid = 1; s_last = 0;
        tick();
        s_data = 16'd0; s_weight = 8'd0; s_bias = 16'h0000;
        tick();
        s_data = 16'd1; s_weight = 8'd1; s_last = 1;
        tick();
        s_valid = 0;
        tick();
        check("wrap_multi", wrap_odata, 16'h0011);
        check("sat_sticky", sat_odata, 16'hFFFF);
        tick();
        check("wrap_valid_clear", wrap_ovalid, 1'b0);

        // Reset mid-packet with a held result pending.
        out_ready = 0;
        send(rnd128(), $urandom, rnd128(), 1'b1);
        tick();
        check("pre_rst_valid", out_valid, 1'b1);
        send(rnd128(), $urandom, rnd128(), 1'b0);
        send(rnd128(), $urandom, rnd128(), 1'b0);
        #2 rst = 1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, 128'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        m_first = 1'b1;
        @(posedge clk);
        #1 rst = 0;
        out_ready = 1;
        send(rnd128(), $urandom, rnd128(), 1'b1);
        drain();

        // Streaming: 100 packets of 4 beats with random bubbles, never stalls.
        n_stall = 0;
        for (int p = 0; p < 100; p++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) tick();
                send(rnd128(), $urandom, rnd128(), b == 3);
            end
        end
        drain();
        check("stream_no_stall", 128'(n_stall), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
